// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 24-bit execution unit; single-cycle logic/arith ops plus an optional
// iterative shift-add multiplier (code 0101), built in when ALU_MUL_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0110;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             illegal_q;

    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic             illegal_d;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    // Single-cycle datapath, evaluated on the live operands and latched at the accept edge.
    always_comb begin
        sum       = op_a + op_b;
        diff      = op_a - op_b;
        result_d  = '0;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        case (alu_ctrl)
            OP_AND: result_d = op_a & op_b;
            OP_OR:  result_d = op_a | op_b;
            OP_ADD: begin
                result_d = sum;
                ovf_d    = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                result_d = diff;
                ovf_d    = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL: result_d = ({27'd0, op_b[4:0]} >= 32'(WIDTH)) ? '0 : (op_a << op_b[4:0]);
`ifdef ALU_MUL_EN
            OP_MUL: result_d = '0;
`endif
            default: illegal_d = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] accNext;

    assign accNext = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    // Control FSM; all handshake and result outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
`ifdef ALU_MUL_EN
                        if (alu_ctrl == OP_MUL) begin
                            state_q  <= MUL;
                            mcand_q  <= op_a;
                            mplier_q <= op_b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else
`endif
                        begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= result_d;
                            zero_q      <= (result_d == '0);
                            ovf_q       <= ovf_d;
                            illegal_q   <= illegal_d;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    acc_q    <= accNext;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    // No early exit: every multiply runs all WIDTH iterations.
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        result_q    <= accNext;
                        zero_q      <= (accNext == '0);
                        ovf_q       <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule
